// File: rtl/multi_sel_acc.sv
// Frames four-term product groups on in_grant and accumulates them into one sum.
// Emits the sum with a strobe, counts groups, and flags framing and ratio-check errors.
module multi_sel_acc #(
  parameter int IN_W    = 11,
  parameter int N_TERMS = 4,
  parameter int SUM_W   = 13,
  parameter int CHK_MUL = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_grant,
  input  logic [IN_W-1:0]  in_data,
  output logic [SUM_W-1:0] sum_out,
  output logic             sum_valid,
  output logic [7:0]       grp_cnt,
  output logic             seq_err,
  output logic             chk_err
);
  localparam int PH_W  = (N_TERMS > 2) ? $clog2(N_TERMS) : 1;
  localparam int CHK_W = IN_W + 5;
  localparam int CMP_W = (SUM_W > CHK_W) ? SUM_W : CHK_W;
  localparam logic [PH_W-1:0] LAST = PH_W'(N_TERMS - 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t            state, state_nxt;
  logic [SUM_W-1:0]  acc, acc_nxt;
  logic [IN_W-1:0]   first, first_nxt;
  logic [PH_W-1:0]   phase, phase_nxt;
  logic              done, abort;
  logic [SUM_W-1:0]  sum_now;
  logic [CHK_W-1:0]  chk_prod;
  logic              mismatch;

  assign sum_now  = acc + SUM_W'(in_data);
  assign chk_prod = CHK_W'(first) * CHK_W'(CHK_MUL);
  assign mismatch = CMP_W'(sum_now) != CMP_W'(chk_prod);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    first_nxt = first;
    phase_nxt = phase;
    done      = 1'b0;
    abort     = 1'b0;
    // A grant always starts a fresh group; in ACC it also drops the partial one.
    if (in_grant) begin
      abort     = (state == ACC);
      acc_nxt   = SUM_W'(in_data);
      first_nxt = in_data;
      phase_nxt = PH_W'(1);
      state_nxt = ACC;
    end else if (state == ACC) begin
      if (phase == LAST) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end else begin
        acc_nxt   = sum_now;
        phase_nxt = phase + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      first     <= '0;
      phase     <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      grp_cnt   <= '0;
      seq_err   <= 1'b0;
      chk_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      first     <= first_nxt;
      phase     <= phase_nxt;
      sum_valid <= done;
      seq_err   <= abort;
      chk_err   <= done & mismatch;
      if (done) begin
        sum_out <= sum_now;
        grp_cnt <= grp_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_multi_sel_acc.sv
// Self-checking bench for multi_sel_acc: directed scenarios plus random traffic
// compared against a queue-based group model.
module tb_multi_sel_acc;
  localparam int IN_W = 11, N_TERMS = 4, SUM_W = 13, CHK_MUL = 19;

  logic             clk = 0;
  logic             rst;
  logic             in_grant;
  logic [IN_W-1:0]  in_data;
  logic [SUM_W-1:0] sum_out;
  logic             sum_valid;
  logic [7:0]       grp_cnt;
  logic             seq_err;
  logic             chk_err;

  int checks = 0;
  int errors = 0;

  // model state
  int unsigned terms[$];
  int unsigned exp_sum;
  bit          exp_valid, exp_seq, exp_chk;
  int unsigned exp_grp;
  int          cyc = 0;

  multi_sel_acc #(.IN_W(IN_W), .N_TERMS(N_TERMS), .SUM_W(SUM_W), .CHK_MUL(CHK_MUL)) dut (
    .clk(clk), .rst(rst), .in_grant(in_grant), .in_data(in_data),
    .sum_out(sum_out), .sum_valid(sum_valid), .grp_cnt(grp_cnt),
    .seq_err(seq_err), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the group model by the same edge, sample 1ns later.
  task automatic drive(input bit r, input bit g, input int unsigned d);
    int unsigned s;
    rst = r; in_grant = g; in_data = d[IN_W-1:0];
    @(posedge clk);
    cyc++;
    exp_valid = 0; exp_seq = 0; exp_chk = 0;
    if (!r) begin
      terms.delete();
      exp_sum = 0; exp_grp = 0;
    end else if (g) begin
      if (terms.size() > 0) exp_seq = 1;
      terms.delete();
      terms.push_back(d % (1 << IN_W));
    end else if (terms.size() > 0) begin
      terms.push_back(d % (1 << IN_W));
      if (terms.size() == N_TERMS) begin
        s = 0;
        foreach (terms[i]) s += terms[i];
        exp_sum   = s % (1 << SUM_W);
        exp_valid = 1;
        exp_chk   = (exp_sum != terms[0] * CHK_MUL);
        exp_grp   = (exp_grp + 1) % 256;
        terms.delete();
      end
    end
    #1;
  endtask

  task automatic group(input int unsigned d);
    drive(1, 1, d); drive(1, 0, 3*d); drive(1, 0, 7*d); drive(1, 0, 8*d);
  endtask

  task automatic test_reset();
    drive(0, 0, 0); drive(0, 1, 5);
    checks++;
    if ({sum_out, sum_valid, grp_cnt, seq_err, chk_err} !== '0) begin
      errors++;
      $display("FAIL reset_state got sum=%0d v=%0b grp=%0d seq=%0b chk=%0b need all 0",
               sum_out, sum_valid, grp_cnt, seq_err, chk_err);
    end
    drive(1, 0, 0);
  endtask

  task automatic test_single();
    group(5);
    checks++;
    if (sum_valid !== 1 || sum_out !== 95 || chk_err !== 0 || grp_cnt !== 1) begin
      errors++;
      $display("FAIL single_group got v=%0b sum=%0d chk=%0b grp=%0d need 1/95/0/1",
               sum_valid, sum_out, chk_err, grp_cnt);
    end
    drive(1, 0, 0);
    checks++;
    if (sum_valid !== 0 || sum_out !== 95) begin
      errors++;
      $display("FAIL strobe_one_cycle got v=%0b sum=%0d need 0/95", sum_valid, sum_out);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    drive(0, 0, 0); drive(1, 0, 0);
    t0 = -1; t1 = -1;
    group(7);
    if (sum_valid === 1) t0 = cyc;
    checks++;
    if (sum_out !== 133 || chk_err !== 0) begin
      errors++; $display("FAIL b2b_first got sum=%0d chk=%0b need 133/0", sum_out, chk_err);
    end
    group(255);
    if (sum_valid === 1) t1 = cyc;
    checks++;
    if (sum_out !== 4845 || grp_cnt !== 2 || chk_err !== 0) begin
      errors++;
      $display("FAIL b2b_second got sum=%0d grp=%0d chk=%0b need 4845/2/0", sum_out, grp_cnt, chk_err);
    end
    checks++;
    if (t0 < 0 || t1 - t0 != 4) begin
      errors++; $display("FAIL b2b_spacing got t0=%0d t1=%0d need 4 apart", t0, t1);
    end
  endtask

  task automatic test_chk_mismatch();
    drive(1, 1, 5); drive(1, 0, 15); drive(1, 0, 35); drive(1, 0, 41);
    checks++;
    if (sum_valid !== 1 || sum_out !== 96 || chk_err !== 1) begin
      errors++;
      $display("FAIL chk_mismatch got v=%0b sum=%0d chk=%0b need 1/96/1", sum_valid, sum_out, chk_err);
    end
    drive(1, 0, 0);
    checks++;
    if (chk_err !== 0) begin
      errors++; $display("FAIL chk_pulse got chk=%0b need 0", chk_err);
    end
  endtask

  task automatic test_seq_err();
    int nseq, nval;
    logic [7:0] g0;
    g0 = grp_cnt; nseq = 0; nval = 0;
    drive(1, 1, 6); nseq += seq_err; nval += sum_valid;
    drive(1, 0, 18); nseq += seq_err; nval += sum_valid;
    drive(1, 1, 1); nseq += seq_err; nval += sum_valid;
    checks++;
    if (seq_err !== 1 || grp_cnt !== g0) begin
      errors++; $display("FAIL seq_err_pulse got seq=%0b grp=%0d need 1/%0d", seq_err, grp_cnt, g0);
    end
    drive(1, 0, 3); nseq += seq_err; nval += sum_valid;
    drive(1, 0, 7); nseq += seq_err; nval += sum_valid;
    drive(1, 0, 8); nseq += seq_err; nval += sum_valid;
    checks++;
    if (nseq != 1 || nval != 1 || sum_out !== 19 || chk_err !== 0 || sum_valid !== 1) begin
      errors++;
      $display("FAIL seq_err_group got nseq=%0d nval=%0d sum=%0d chk=%0b need 1/1/19/0",
               nseq, nval, sum_out, chk_err);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 9); drive(1, 0, 27);
    drive(0, 0, 63);
    checks++;
    if ({sum_out, sum_valid, grp_cnt, seq_err, chk_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid got sum=%0d v=%0b grp=%0d seq=%0b chk=%0b need all 0",
               sum_out, sum_valid, grp_cnt, seq_err, chk_err);
    end
    drive(1, 0, 72);
    checks++;
    if (sum_valid !== 0) begin
      errors++; $display("FAIL reset_mid_nostrobe got v=%0b need 0", sum_valid);
    end
    group(1);
    checks++;
    if (sum_valid !== 1 || sum_out !== 19 || grp_cnt !== 1) begin
      errors++;
      $display("FAIL reset_mid_fresh got v=%0b sum=%0d grp=%0d need 1/19/1", sum_valid, sum_out, grp_cnt);
    end
  endtask

  task automatic test_wrap();
    int unsigned d;
    drive(0, 0, 0); drive(1, 0, 0);
    for (int i = 0; i < 256; i++) begin
      d = $urandom_range(255, 1);
      group(d);
      if (i == 254) begin
        checks++;
        if (grp_cnt !== 255) begin
          errors++; $display("FAIL wrap_255 got grp=%0d need 255", grp_cnt);
        end
      end
    end
    checks++;
    if (grp_cnt !== 0 || sum_valid !== 1 || sum_out !== 19 * d || chk_err !== 0) begin
      errors++;
      $display("FAIL wrap_zero got grp=%0d v=%0b sum=%0d chk=%0b need 0/1/%0d/0",
               grp_cnt, sum_valid, sum_out, chk_err, 19 * d);
    end
  endtask

  task automatic test_random();
    int unsigned d;
    bit g;
    for (int i = 0; i < 2000; i++) begin
      g = ($urandom_range(99) < 30);
      d = ($urandom_range(3) == 0) ? $urandom_range(2047) : $urandom_range(255);
      drive(($urandom_range(199) != 0), g, d);
      checks++;
      if (sum_valid !== exp_valid || seq_err !== exp_seq || chk_err !== exp_chk ||
          grp_cnt !== exp_grp[7:0] || sum_out !== exp_sum[SUM_W-1:0]) begin
        errors++;
        $display("FAIL random_cyc%0d got v=%0b seq=%0b chk=%0b grp=%0d sum=%0d need %0b/%0b/%0b/%0d/%0d",
                 i, sum_valid, seq_err, chk_err, grp_cnt, sum_out,
                 exp_valid, exp_seq, exp_chk, exp_grp, exp_sum);
      end
    end
  endtask

  initial begin
    rst = 0; in_grant = 0; in_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_chk_mismatch();
    test_seq_err();
    test_reset_mid();
    test_wrap();
    drive(0, 0, 0);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
